// File: rtl/control_unit.sv
// control_unit: fetch/decode/indirect/execute sequencer driving every datapath strobe.
// Optional CU_HALT_EN: IR 0x7001 decodes as HLT and enables the HALT state.
module control_unit #(
    parameter int unsigned P_MEM_LAT = 2,
    parameter int unsigned P_EXEC_TO = 15
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [15:0] i_ir,
    input  logic        i_ex_done,
    output logic        o_clr_reg,
    output logic        o_fetch,
    output logic        o_execute,
    output logic        o_is_ind,
    output logic        o_is_dir,
    output logic        o_clr_ac,
    output logic        o_clr_e,
    output logic        o_comp_ac,
    output logic        o_load_ac,
    output logic        o_cir_r,
    output logic        o_cir_l,
    output logic        o_inc_ac,
    output logic        o_add,
    output logic        o_load,
    output logic        o_store,
    output logic        o_branch,
    output logic        o_isz,
    output logic        o_running,
    output logic        o_halted,
    output logic        o_fault,
    output logic [15:0] o_icount
);
    localparam int unsigned LP_IR_W    = 16;
    localparam int unsigned LP_WAIT_W  = 3;
    localparam int unsigned LP_DWELL_W = 8;
    localparam int unsigned LP_SEL_W   = 12;
    localparam logic [LP_WAIT_W-1:0]  LP_WAIT_LAST  = LP_WAIT_W'(P_MEM_LAT - 1);
    localparam logic [LP_DWELL_W-1:0] LP_DWELL_LAST = LP_DWELL_W'(P_EXEC_TO - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_FETCH, S_WAIT_IR, S_DECODE,
        S_INDIRECT, S_WAIT_IND, S_EXEC, S_HALT, S_FAULT
    } state_t;

    state_t                r_state, w_next;
    logic [LP_IR_W-1:0]    r_ir;
    logic [LP_WAIT_W-1:0]  r_wait;
    logic [LP_DWELL_W-1:0] r_dwell;
    logic                  r_stop;
    logic [LP_IR_W-1:0]    r_icount;
    logic [LP_SEL_W-1:0]   r_sel;
    logic                  r_clr_reg, r_fetch, r_execute, r_is_ind, r_is_dir;
    logic                  r_running, r_halted, r_fault;

    logic                  w_ind, w_is_mem, w_is_reg, w_is_hlt;
    logic                  w_retire, w_stop_any, w_run_now;
    logic [2:0]            w_op;
    logic [LP_SEL_W-1:0]   w_dec_sel;

    assign w_ind      = r_ir[15];
    assign w_op       = r_ir[14:12];
    assign w_is_reg   = (w_op == 3'd7) && !w_ind && (|r_ir[11:5]);
    assign w_run_now  = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_FAULT);
    assign w_stop_any = r_stop | i_stop;

`ifdef CU_HALT_EN
    assign w_is_hlt = (r_ir == 16'h7001);
`else
    logic w_unused_ir;
    assign w_is_hlt    = 1'b0;
    assign w_unused_ir = ^r_ir[4:0];
`endif

    // Select layout: [11:5] register-reference (mirrors IR[11:5]), [4:0] add/load/store/branch/isz
    always_comb begin
        w_dec_sel = '0;
        w_is_mem  = 1'b0;
        case (w_op)
            3'd1: begin w_is_mem = 1'b1; w_dec_sel[4] = 1'b1; end
            3'd2: begin w_is_mem = 1'b1; w_dec_sel[3] = 1'b1; end
            3'd3: begin w_is_mem = 1'b1; w_dec_sel[2] = 1'b1; end
            3'd4: begin w_is_mem = 1'b1; w_dec_sel[1] = 1'b1; end
            3'd6: begin w_is_mem = 1'b1; w_dec_sel[0] = 1'b1; end
            default: ;
        endcase
        if ((w_op == 3'd7) && !w_ind) begin
            if      (r_ir[11]) w_dec_sel[11] = 1'b1;
            else if (r_ir[10]) w_dec_sel[10] = 1'b1;
            else if (r_ir[9])  w_dec_sel[9]  = 1'b1;
            else if (r_ir[8])  w_dec_sel[8]  = 1'b1;
            else if (r_ir[7])  w_dec_sel[7]  = 1'b1;
            else if (r_ir[6])  w_dec_sel[6]  = 1'b1;
            else if (r_ir[5])  w_dec_sel[5]  = 1'b1;
        end
    end

    // Next-state and retire decision
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE:     if (i_start) w_next = S_CLR;
            S_CLR:      w_next = S_FETCH;
            S_FETCH:    w_next = S_WAIT_IR;
            S_WAIT_IR:  if (r_wait == LP_WAIT_LAST) w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_hlt) begin
                    w_retire = 1'b1;
                    w_next   = S_HALT;
                end else if (w_is_mem) begin
                    w_next = w_ind ? S_INDIRECT : S_EXEC;
                end else if (w_is_reg) begin
                    w_next = S_EXEC;
                end else begin
                    w_retire = 1'b1;
                    w_next   = w_stop_any ? S_IDLE : S_FETCH;
                end
            end
            S_INDIRECT: w_next = S_WAIT_IND;
            S_WAIT_IND: if (r_wait == LP_WAIT_LAST) w_next = S_EXEC;
            S_EXEC: begin
                // first-cycle ex_done is stale from the previous instruction
                if (i_ex_done && (r_dwell != '0)) begin
                    w_retire = 1'b1;
                    w_next   = w_stop_any ? S_IDLE : S_FETCH;
                end else if (r_dwell == LP_DWELL_LAST) begin
                    w_next = S_FAULT;
                end
            end
`ifdef CU_HALT_EN
            S_HALT:     if (i_start) w_next = S_FETCH;
`else
            S_HALT:     w_next = S_IDLE;
`endif
            S_FAULT:    w_next = S_FAULT;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_wait    <= '0;
            r_dwell   <= '0;
            r_stop    <= 1'b0;
            r_icount  <= '0;
            r_sel     <= '0;
            r_clr_reg <= 1'b0;
            r_fetch   <= 1'b0;
            r_execute <= 1'b0;
            r_is_ind  <= 1'b0;
            r_is_dir  <= 1'b0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_WAIT_IR) && (w_next == S_DECODE)) r_ir <= i_ir;
            if (w_next != r_state)
                r_wait <= '0;
            else if ((r_state == S_WAIT_IR) || (r_state == S_WAIT_IND))
                r_wait <= r_wait + 1'b1;
            if (w_next != S_EXEC)
                r_dwell <= '0;
            else if ((r_state == S_EXEC) && (r_dwell != '1))
                r_dwell <= r_dwell + 1'b1;
            if (w_next == S_IDLE)
                r_stop <= 1'b0;
            else if (w_run_now && i_stop)
                r_stop <= 1'b1;
            if (w_retire) r_icount <= r_icount + 16'd1;
            // Moore outputs registered from the state being entered
            r_clr_reg <= (w_next == S_CLR);
            r_fetch   <= (w_next == S_FETCH);
            r_execute <= (w_next == S_EXEC);
            r_is_ind  <= (w_next == S_INDIRECT);
            r_is_dir  <= (w_next == S_EXEC) && w_is_mem;
            r_sel     <= (w_next == S_EXEC) ? w_dec_sel : '0;
            r_running <= (w_next != S_IDLE) && (w_next != S_HALT) && (w_next != S_FAULT);
`ifdef CU_HALT_EN
            r_halted  <= (w_next == S_HALT);
`else
            r_halted  <= 1'b0;
`endif
            r_fault   <= (w_next == S_FAULT);
        end
    end

    assign o_clr_reg = r_clr_reg;
    assign o_fetch   = r_fetch;
    assign o_execute = r_execute;
    assign o_is_ind  = r_is_ind;
    assign o_is_dir  = r_is_dir;
    assign {o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac,
            o_add, o_load, o_store, o_branch, o_isz} = r_sel;
    assign o_running = r_running;
    assign o_halted  = r_halted;
    assign o_fault   = r_fault;
    assign o_icount  = r_icount;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit at default parameters (P_MEM_LAT=2, P_EXEC_TO=15).
module tb_control_unit;
    logic        clk;
    logic        i_rst_n, i_start, i_stop, i_ex_done;
    logic [15:0] i_ir;
    logic        o_clr_reg, o_fetch, o_execute, o_is_ind, o_is_dir;
    logic        o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac;
    logic        o_add, o_load, o_store, o_branch, o_isz;
    logic        o_running, o_halted, o_fault;
    logic [15:0] o_icount;
    logic [11:0] sel;

    int n_vec = 0;
    int n_err = 0;

    control_unit dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_ir(i_ir), .i_ex_done(i_ex_done),
        .o_clr_reg(o_clr_reg), .o_fetch(o_fetch), .o_execute(o_execute),
        .o_is_ind(o_is_ind), .o_is_dir(o_is_dir),
        .o_clr_ac(o_clr_ac), .o_clr_e(o_clr_e), .o_comp_ac(o_comp_ac),
        .o_load_ac(o_load_ac), .o_cir_r(o_cir_r), .o_cir_l(o_cir_l), .o_inc_ac(o_inc_ac),
        .o_add(o_add), .o_load(o_load), .o_store(o_store), .o_branch(o_branch), .o_isz(o_isz),
        .o_running(o_running), .o_halted(o_halted), .o_fault(o_fault), .o_icount(o_icount)
    );

    assign sel = {o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac,
                  o_add, o_load, o_store, o_branch, o_isz};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_ex_done = 1'b0; i_ir = 16'h0000;
        #12;
        chk1("rst_running", o_running, 1'b0);
        chk1("rst_fault", o_fault, 1'b0);
        chk1("rst_halted", o_halted, 1'b0);
        chk1("rst_clr_reg", o_clr_reg, 1'b0);
        chk1("rst_fetch", o_fetch, 1'b0);
        chkv("rst_icount", o_icount, 16'h0000);
        chkv("rst_sel", 16'(sel), 16'h0000);
        i_rst_n = 1'b1;
        step(1);
        chk1("idle_running", o_running, 1'b0);

        // LDA direct: clr, fetch, 2-cycle exec with stale ex_done in cycle 1
        i_start = 1'b1; step(1); i_start = 1'b0; i_ir = 16'h2010;
        chk1("lda_clr_reg", o_clr_reg, 1'b1);
        chk1("lda_running", o_running, 1'b1);
        step(1);
        chk1("lda_fetch", o_fetch, 1'b1);
        chk1("lda_clr_off", o_clr_reg, 1'b0);
        step(3);
        chk1("lda_decode_noexec", o_execute, 1'b0);
        step(1);
        chk1("lda_execute", o_execute, 1'b1);
        chkv("lda_sel", 16'(sel), 16'h0008);
        chk1("lda_is_dir", o_is_dir, 1'b1);
        i_ex_done = 1'b1; step(1);
        chk1("lda_stale_done", o_execute, 1'b1);
        chkv("lda_sel_hold", 16'(sel), 16'h0008);
        step(1); i_ex_done = 1'b0;
        chk1("lda_exec_end", o_execute, 1'b0);
        chk1("lda_refetch", o_fetch, 1'b1);
        chkv("lda_icount", o_icount, 16'h0001);

        // ADD indirect
        i_ir = 16'h9010;
        step(4);
        chk1("add_is_ind", o_is_ind, 1'b1);
        chk1("add_ind_noexec", o_execute, 1'b0);
        step(1);
        chk1("add_is_ind_off", o_is_ind, 1'b0);
        step(1);
        chk1("add_wait_noexec", o_execute, 1'b0);
        step(1);
        chk1("add_execute", o_execute, 1'b1);
        chkv("add_sel", 16'(sel), 16'h0010);
        i_ex_done = 1'b1; step(2); i_ex_done = 1'b0;
        chkv("add_icount", o_icount, 16'h0002);

        // Register reference 0x7A20: only clr_ac wins
        i_ir = 16'h7A20;
        step(4);
        chk1("rr_execute", o_execute, 1'b1);
        chkv("rr_sel", 16'(sel), 16'h0800);
        chk1("rr_is_dir", o_is_dir, 1'b0);
        i_ex_done = 1'b1; step(2); i_ex_done = 1'b0;
        chkv("rr_icount", o_icount, 16'h0003);

        // Opcode 0: NOP retire without execute
        i_ir = 16'h0010;
        step(3);
        chk1("nop_decode", o_execute, 1'b0);
        step(1);
        chk1("nop_noexec", o_execute, 1'b0);
        chk1("nop_fetch", o_fetch, 1'b1);
        chkv("nop_icount", o_icount, 16'h0004);

        // BUN with ex_done never arriving: fault after 15 exec cycles
        i_ir = 16'h4020;
        step(4);
        chkv("bun_sel", 16'(sel), 16'h0002);
        step(14);
        chk1("to_last_exec", o_execute, 1'b1);
        chk1("to_not_yet", o_fault, 1'b0);
        step(1);
        chk1("to_fault", o_fault, 1'b1);
        chk1("to_exec_off", o_execute, 1'b0);
        chkv("to_sel_off", 16'(sel), 16'h0000);
        chk1("to_running", o_running, 1'b0);
        chkv("to_icount", o_icount, 16'h0004);
        i_start = 1'b1; step(2); i_start = 1'b0;
        chk1("to_start_ignored", o_fault, 1'b1);
        chk1("to_no_clr", o_clr_reg, 1'b0);
        #1 i_rst_n = 1'b0; #1;
        chk1("to_rst_fault", o_fault, 1'b0);
        chkv("to_rst_icount", o_icount, 16'h0000);
        i_rst_n = 1'b1;
        step(1);

        // Stop during WAIT_IR: instruction completes then IDLE
        i_ir = 16'h2010;
        i_start = 1'b1; step(1); i_start = 1'b0;
        step(2);
        i_stop = 1'b1; step(1); i_stop = 1'b0;
        step(2);
        chk1("stop_execute", o_execute, 1'b1);
        i_ex_done = 1'b1; step(2); i_ex_done = 1'b0;
        chk1("stop_idle", o_running, 1'b0);
        chk1("stop_no_fetch", o_fetch, 1'b0);
        chkv("stop_icount", o_icount, 16'h0001);
        step(3);
        chk1("stop_stays_idle", o_running, 1'b0);

        // Asynchronous reset mid-EXEC
        i_start = 1'b1; step(1); i_start = 1'b0;
        step(5);
        chk1("ar_execute", o_execute, 1'b1);
        #1 i_rst_n = 1'b0; #1;
        chk1("ar_exec_off", o_execute, 1'b0);
        chkv("ar_sel_off", 16'(sel), 16'h0000);
        chk1("ar_running", o_running, 1'b0);
        chkv("ar_icount", o_icount, 16'h0000);
        i_rst_n = 1'b1;
        step(3);
        chk1("ar_stays_idle", o_running, 1'b0);
        chk1("ar_no_clr", o_clr_reg, 1'b0);

        // 0x7001: HLT when enabled, otherwise NOP
        i_ir = 16'h7001;
        i_start = 1'b1; step(1); i_start = 1'b0;
        step(5);
`ifdef CU_HALT_EN
        chk1("hlt_halted", o_halted, 1'b1);
        chk1("hlt_running", o_running, 1'b0);
        chkv("hlt_icount", o_icount, 16'h0001);
        i_start = 1'b1; step(1); i_start = 1'b0;
        chk1("hlt_resume_fetch", o_fetch, 1'b1);
        chk1("hlt_resume_no_clr", o_clr_reg, 1'b0);
        chk1("hlt_resume_halted", o_halted, 1'b0);
`else
        chk1("hlt_nop_halted", o_halted, 1'b0);
        chk1("hlt_nop_fetch", o_fetch, 1'b1);
        chkv("hlt_nop_icount", o_icount, 16'h0001);
        step(4);
        chkv("hlt_nop_icount2", o_icount, 16'h0002);
        chk1("hlt_nop_running", o_running, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
